// File: rtl/risk_tile_lsu.sv
// risk_tile_lsu: strided SZ x SZ tile load/store engine between NREG tile registers and an
// SZ-bank memory, one row per cycle; all memory-side outputs come straight from registers.
module risk_tile_lsu #(
  parameter  int SZ       = 4,
  parameter  int ELEM_W   = 18,
  parameter  int ADDR_W   = 15,
  parameter  int STRIDE_W = 14,
  parameter  int NREG     = 32,
  parameter  int RD_LAT   = 1,
  localparam int REG_W    = $clog2(NREG)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_func,
  input  logic [REG_W-1:0]            cmd_reg,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [STRIDE_W-1:0]         cmd_stride_x,
  input  logic [STRIDE_W-1:0]         cmd_stride_y,
  output logic [SZ-1:0]               mem_en,
  output logic                        mem_we,
  output logic [SZ*ADDR_W-1:0]        mem_addr,
  output logic [SZ*ELEM_W-1:0]        mem_wdata,
  input  logic [SZ*ELEM_W-1:0]        mem_rdata,
  input  logic [REG_W-1:0]            view_reg,
  output logic [SZ*SZ*ELEM_W-1:0]     reg_view,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int ROW_W = $clog2(SZ);
  localparam int CNT_W = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  typedef enum logic [2:0] {
    F_NOP   = 3'b000,
    F_STORE = 3'b001,
    F_LOAD  = 3'b010,
    F_ZERO  = 3'b011
  } func_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ROW_W-1:0]       row_q;
  logic [2:0]             func_q;
  logic [REG_W-1:0]       reg_q;
  logic [ADDR_W-1:0]      sx_q, sy_q, row_base_q, lane_acc;
  logic [SZ-1:0]          mem_en_q;
  logic                   mem_we_q;
  logic [SZ*ADDR_W-1:0]   mem_addr_q, lane_addr;
  logic [SZ*ELEM_W-1:0]   mem_wdata_q, row_wdata;
  logic                   tag_vld_q [RD_LAT+1];
  logic [ROW_W-1:0]       tag_row_q [RD_LAT+1];
  logic [ELEM_W-1:0]      tiles_q [NREG][SZ][SZ];
  logic                   accept, in_run, is_load, is_store, last_row;

  assign cmd_ready = (state_q == S_IDLE) & resetn;
  assign accept    = cmd_valid & cmd_ready;
  assign in_run    = (state_q == S_RUN);
  assign is_load   = (func_q == F_LOAD);
  assign is_store  = (func_q == F_STORE);
  assign last_row  = (row_q == ROW_W'(SZ - 1));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & func_q[2];

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // DRAIN covers the output register stage plus, for LOAD, the read latency.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_func == F_STORE || cmd_func == F_LOAD) begin
            state_d = S_RUN;
          end else begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (last_row) begin
          state_d = S_DRAIN;
          cnt_d   = is_load ? CNT_W'(RD_LAT) : '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lane addresses are an adder chain from the row base, so no multiplier sits on the row path.
  always_comb begin
    lane_acc  = row_base_q;
    lane_addr = '0;
    row_wdata = '0;
    for (int x = 0; x < SZ; x++) begin
      lane_addr[x*ADDR_W +: ADDR_W] = lane_acc;
      lane_acc                      = lane_acc + sx_q;
      row_wdata[x*ELEM_W +: ELEM_W] = tiles_q[reg_q][row_q][x];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      func_q      <= '0;
      reg_q       <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      row_base_q  <= '0;
      row_q       <= '0;
      mem_en_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_row_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        func_q     <= cmd_func;
        reg_q      <= cmd_reg;
        sx_q       <= ADDR_W'(cmd_stride_x);
        sy_q       <= ADDR_W'(cmd_stride_y);
        row_base_q <= cmd_addr;
        row_q      <= '0;
      end else if (in_run) begin
        row_base_q <= row_base_q + sy_q;
        row_q      <= row_q + ROW_W'(1);
      end
      mem_en_q     <= in_run ? '1 : '0;
      mem_we_q     <= in_run & is_store;
      mem_addr_q   <= in_run ? lane_addr : '0;
      mem_wdata_q  <= (in_run & is_store) ? row_wdata : '0;
      // Stage 0 travels with the registered read request; stage RD_LAT meets its data.
      tag_vld_q[0] <= in_run & is_load;
      tag_row_q[0] <= row_q;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_row_q[i] <= tag_row_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the tile file is architecturally visible through reg_view, so it is reset like any state.
      for (int r = 0; r < NREG; r++)
        for (int y = 0; y < SZ; y++)
          for (int x = 0; x < SZ; x++)
            tiles_q[r][y][x] <= '0;
    end else begin
      if (state_q == S_DRAIN && func_q == F_ZERO) begin
        for (int y = 0; y < SZ; y++)
          for (int x = 0; x < SZ; x++)
            tiles_q[reg_q][y][x] <= '0;
      end
      if (tag_vld_q[RD_LAT]) begin
        for (int x = 0; x < SZ; x++)
          tiles_q[reg_q][tag_row_q[RD_LAT]][x] <= mem_rdata[x*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    reg_view = '0;
    for (int y = 0; y < SZ; y++)
      for (int x = 0; x < SZ; x++)
        reg_view[(y*SZ+x)*ELEM_W +: ELEM_W] = tiles_q[view_reg][y][x];
  end

endmodule

// File: tb/tb_risk_tile_lsu.sv
// Directed bench for risk_tile_lsu (SZ=4, RD_LAT=1) against a flat memory where unwritten
// locations read back their own address.
module tb_risk_tile_lsu;

  localparam int SZ = 4, EW = 18, AW = 15, SW = 14, NREG = 32, RD_LAT = 1, RW = 5;
  localparam int VW = SZ*SZ*EW;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_func = '0;
  logic [RW-1:0]      cmd_reg = '0;
  logic [AW-1:0]      cmd_addr = '0;
  logic [SW-1:0]      cmd_stride_x = '0;
  logic [SW-1:0]      cmd_stride_y = '0;
  logic [SZ-1:0]      mem_en;
  logic               mem_we;
  logic [SZ*AW-1:0]   mem_addr;
  logic [SZ*EW-1:0]   mem_wdata;
  logic [SZ*EW-1:0]   mem_rdata = '0;
  logic [RW-1:0]      view_reg = '0;
  logic [VW-1:0]      reg_view;
  logic               busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [SZ-1:0]      tr_en    [0:63];
  logic               tr_we    [0:63];
  logic [SZ*AW-1:0]   tr_addr  [0:63];
  logic [SZ*EW-1:0]   tr_wdata [0:63];

  bit [EW-1:0]        mem     [0:(1<<AW)-1];
  bit                 written [0:(1<<AW)-1];

  risk_tile_lsu #(.SZ(SZ), .ELEM_W(EW), .ADDR_W(AW), .STRIDE_W(SW), .NREG(NREG), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
    .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .view_reg(view_reg), .reg_view(reg_view), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model_rd(input logic [AW-1:0] a);
    return written[a] ? mem[a] : EW'(a);
  endfunction

  // Memory model with one-cycle read latency.
  always @(posedge clk) begin
    for (int x = 0; x < SZ; x++) begin
      if (mem_en[x]) begin
        if (mem_we) begin
          mem[mem_addr[x*AW +: AW]]     <= mem_wdata[x*EW +: EW];
          written[mem_addr[x*AW +: AW]] <= 1'b1;
        end else begin
          mem_rdata[x*EW +: EW] <= model_rd(mem_addr[x*AW +: AW]);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] view_of(input int base, input int sy, input int sx);
    logic [VW-1:0] v;
    v = '0;
    for (int y = 0; y < SZ; y++)
      for (int x = 0; x < SZ; x++)
        v[(y*SZ+x)*EW +: EW] = EW'(base + y*sy + x*sx);
    return v;
  endfunction

  task automatic record(input int k);
    tr_en[k]    = mem_en;
    tr_we[k]    = mem_we;
    tr_addr[k]  = mem_addr;
    tr_wdata[k] = mem_wdata;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic wait_done(output int lat, output logic err_at_done);
    lat = -1;
    err_at_done = 1'b0;
    for (int k = 1; k < 48; k++) begin
      @(posedge clk);
      #1;
      record(k);
      if (done) begin
        lat = k;
        err_at_done = err;
        break;
      end
    end
  endtask

  task automatic run_cmd(input logic [2:0] f, input logic [RW-1:0] r, input logic [AW-1:0] a,
                         input logic [SW-1:0] sx, input logic [SW-1:0] sy,
                         output int lat, output logic err_at_done);
    wait_ready();
    cmd_func = f; cmd_reg = r; cmd_addr = a; cmd_stride_x = sx; cmd_stride_y = sy;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    record(0);
    wait_done(lat, err_at_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic e;

    // Reset state
    #12;
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_mem_en", mem_en, 4'h0);
    check("rst_busy_done_err", {busy, done, err}, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_ready_rel", cmd_ready, 1'b1);
    check("rst_view0", reg_view, '0);

    // 1: LOAD reg0, addr 0, sx 1, sy 4
    run_cmd(3'b010, 5'd0, 15'h0000, 14'd1, 14'd4, lat, e);
    check("t1_lat", lat, 6);
    check("t1_k0_en", tr_en[0], 4'h0);
    check("t1_row0_en_we", {tr_en[1], tr_we[1]}, {4'hF, 1'b0});
    check("t1_row0_addr", tr_addr[1], {15'd3, 15'd2, 15'd1, 15'd0});
    check("t1_row1_addr", tr_addr[2], {15'd7, 15'd6, 15'd5, 15'd4});
    check("t1_row3_addr", tr_addr[4], {15'd15, 15'd14, 15'd13, 15'd12});
    check("t1_after_rows", {tr_en[5], tr_addr[5]}, '0);
    view_reg = 5'd0;
    #1;
    check("t1_view", reg_view, view_of(0, 4, 1));
    @(posedge clk);
    #1;
    check("t1_post_done", {done, busy, cmd_ready}, 3'b001);

    // 2: STORE reg0 transposed to 0x100
    run_cmd(3'b001, 5'd0, 15'h0100, 14'd4, 14'd1, lat, e);
    check("t2_lat", lat, 5);
    check("t2_row0_addr", tr_addr[1], {15'h10C, 15'h108, 15'h104, 15'h100});
    check("t2_row0_wdata", tr_wdata[1], {18'd3, 18'd2, 18'd1, 18'd0});
    check("t2_row3_addr", tr_addr[4], {15'h10F, 15'h10B, 15'h107, 15'h103});
    check("t2_row3_wdata", tr_wdata[4], {18'd15, 18'd14, 18'd13, 18'd12});
    check("t2_we_rows", {tr_we[1], tr_we[2], tr_we[3], tr_we[4], tr_we[5]}, 5'b11110);
    check("t2_after_wdata", tr_wdata[5], '0);
    for (int y = 0; y < SZ; y++)
      for (int x = 0; x < SZ; x++)
        check($sformatf("t2_mem_y%0d_x%0d", y, x), model_rd(AW'(16'h100 + 4*x + y)), EW'(4*y + x));

    // 3: LOAD reg1 with wrapping lane addresses, sy 0
    run_cmd(3'b010, 5'd1, 15'h7FFE, 14'd1, 14'd0, lat, e);
    check("t3_lat", lat, 6);
    check("t3_row0_addr", tr_addr[1], {15'h0001, 15'h0000, 15'h7FFF, 15'h7FFE});
    check("t3_row3_addr", tr_addr[4], {15'h0001, 15'h0000, 15'h7FFF, 15'h7FFE});
    view_reg = 5'd1;
    #1;
    check("t3_view", reg_view, {4{18'h00001, 18'h00000, 18'h07FFF, 18'h07FFE}});

    // 4: cmd_valid held high across a LOAD; second copy accepted only after done
    wait_ready();
    cmd_func = 3'b010; cmd_reg = 5'd3; cmd_addr = 15'h0010; cmd_stride_x = 14'd1; cmd_stride_y = 14'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t4_ready_k0", cmd_ready, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_ready_k%0d", k), {cmd_ready, busy}, 2'b01);
    end
    check("t4_done_k6", done, 1'b1);
    @(posedge clk);
    #1;
    check("t4_k7_idle", {cmd_ready, busy, done}, 3'b100);
    @(posedge clk);
    #1;
    check("t4_k8_reaccept", {cmd_ready, busy}, 2'b01);
    cmd_valid = 1'b0;
    wait_done(lat, e);
    check("t4_lat2", lat, 6);
    view_reg = 5'd3;
    #1;
    check("t4_view", reg_view, view_of(16, 4, 1));

    // 5: ZERO reg0, then an illegal func
    view_reg = 5'd0;
    #1;
    check("t5_view_pre", reg_view, view_of(0, 4, 1));
    run_cmd(3'b011, 5'd0, 15'h0000, 14'd0, 14'd0, lat, e);
    check("t5_zero_lat", lat, 1);
    check("t5_zero_err", e, 1'b0);
    check("t5_zero_view", reg_view, '0);
    run_cmd(3'b101, 5'd1, 15'h0100, 14'd1, 14'd1, lat, e);
    check("t5_ill_lat", lat, 1);
    check("t5_ill_err", e, 1'b1);
    check("t5_ill_no_mem", {tr_en[0], tr_en[1]}, 8'h00);
    @(posedge clk);
    #1;
    check("t5_pulse_end", {done, err}, 2'b00);
    check("t5_mem_kept", model_rd(15'h0101), 18'd4);
    view_reg = 5'd1;
    #1;
    check("t5_reg1_kept", reg_view, {4{18'h00001, 18'h00000, 18'h07FFF, 18'h07FFE}});

    // 6: reset during row 2 of a LOAD, then a clean LOAD
    wait_ready();
    cmd_func = 3'b010; cmd_reg = 5'd2; cmd_addr = 15'h0000; cmd_stride_x = 14'd1; cmd_stride_y = 14'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_row2_active", {mem_en, busy}, 5'b11111);
    #1;
    resetn = 1'b0;
    #1;
    check("t6_rst_outputs", {mem_en, mem_we, busy, done, err, cmd_ready}, 9'b0);
    check("t6_rst_addr", mem_addr, '0);
    check("t6_rst_reg1", reg_view, '0);
    view_reg = 5'd2;
    #1;
    check("t6_rst_reg2", reg_view, '0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("t6_ready_rel", cmd_ready, 1'b1);
    run_cmd(3'b010, 5'd2, 15'h0000, 14'd1, 14'd4, lat, e);
    check("t6_lat", lat, 6);
    check("t6_view", reg_view, view_of(0, 4, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
